// File: rtl/dw_bsr_chain.sv
// Boundary-scan register chain: WIDTH capture/shift cells, each backed by an update latch stage.
// Optional build macro DW_BSR_SO_RETIME_EN adds a register on the serial output.
module dw_bsr_chain #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] SAFE_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             mode,
  input  logic             si,
  input  logic [WIDTH-1:0] data_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             so,
  output logic             shift_len_err
);

  localparam int               CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURED = 2'd1,
    ST_SHIFTING = 2'd2
  } state_e;

  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter holds at all-ones so an overlong shift can never wrap back onto WIDTH.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cap_d = cap_q;
    if (capture_dr) begin
      cap_d = data_in;
    end else if (shift_dr) begin
      cap_d = {si, cap_q[WIDTH-1:1]};
    end
    upd_d = update_dr ? cap_q : upd_q;
  end

  // sh_state/sh_cnt describe the chain after this cycle's shift, which the length check must include.
  state_e           sh_state;
  logic [CNT_W-1:0] sh_cnt;
  logic             len_bad;

  always_comb begin
    sh_state = state_q;
    sh_cnt   = cnt_q;
    if (shift_dr && !capture_dr) begin
      case (state_q)
        ST_CAPTURED: begin
          sh_state = ST_SHIFTING;
          sh_cnt   = CNT_W'(1);
        end
        ST_SHIFTING: sh_cnt = sat_inc(cnt_q);
        default: ;
      endcase
    end

    len_bad = update_dr && (sh_state == ST_SHIFTING) && (sh_cnt != CNT_FULL);

    state_d = sh_state;
    cnt_d   = sh_cnt;
    if (update_dr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
    if (capture_dr) begin
      state_d = ST_CAPTURED;
      cnt_d   = '0;
    end

    if (len_bad) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q   <= '0;
      upd_q   <= SAFE_VALUE;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      upd_q   <= upd_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef DW_BSR_SO_RETIME_EN
  logic so_q, so_d;

  always_comb so_d = cap_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      so_q <= 1'b0;
    end else begin
      so_q <= so_d;
    end
  end

  assign so = so_q;
`else
  assign so = cap_q[0];
`endif

  assign data_out      = mode ? upd_q : data_in;
  assign shift_len_err = err_q;

endmodule

// File: tb/tb_dw_bsr_chain.sv
// Directed bench for dw_bsr_chain (WIDTH=8, SAFE_VALUE=8'hA5) with a shift-count reference model.
module tb_dw_bsr_chain;

  localparam int         WIDTH = 8;
  localparam logic [7:0] SAFE  = 8'hA5;

  logic       clk;
  logic       rst;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       mode;
  logic       si;
  logic [7:0] data_in;
  logic       err_clr;
  logic [7:0] data_out;
  logic       so;
  logic       shift_len_err;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 0;

  dw_bsr_chain #(.WIDTH(WIDTH), .SAFE_VALUE(SAFE)) dut (
    .clk(clk), .rst(rst), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .mode(mode), .si(si), .data_in(data_in),
    .err_clr(err_clr), .data_out(data_out), .so(so), .shift_len_err(shift_len_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: chain as a plain vector, a "capture pending" flag and an unbounded shift count.
  logic [7:0] m_cap, m_upd;
  logic       m_err, m_so_q, m_armed;
  int         m_nsh;

  always @(posedge clk) begin
    logic [7:0] old_cap;
    int         nsh;
    logic       set_err;
    if (rst) begin
      m_cap = '0; m_upd = SAFE; m_err = 0; m_so_q = 0; m_armed = 0; m_nsh = 0;
    end else begin
      old_cap = m_cap;
      nsh     = m_nsh + ((shift_dr && !capture_dr && m_armed) ? 1 : 0);
      set_err = update_dr && m_armed && (nsh > 0) && (nsh != WIDTH);
      if (capture_dr)     m_cap = data_in;
      else if (shift_dr)  m_cap = {si, m_cap[7:1]};
      if (update_dr)      m_upd = old_cap;
      if (set_err)        m_err = 1;
      else if (err_clr)   m_err = 0;
      if (capture_dr) begin
        m_armed = 1; m_nsh = 0;
      end else if (update_dr) begin
        m_armed = 0; m_nsh = 0;
      end else begin
        m_nsh = nsh;
      end
      m_so_q = old_cap[0];
    end
  end

  always @(negedge clk) begin
    logic exp_so;
    if (check_en) begin
`ifdef DW_BSR_SO_RETIME_EN
      exp_so = m_so_q;
`else
      exp_so = m_cap[0];
`endif
      chk("cyc_data_out", {24'h0, data_out}, {24'h0, (mode ? m_upd : data_in)});
      chk("cyc_so", {31'h0, so}, {31'h0, exp_so});
      chk("cyc_err", {31'h0, shift_len_err}, {31'h0, m_err});
    end
  end

  task automatic cyc(input logic c, input logic s, input logic u, input logic si_v, input logic clr);
    capture_dr = c; shift_dr = s; update_dr = u; si = si_v; err_clr = clr;
    @(posedge clk);
    #2;
    capture_dr = 0; shift_dr = 0; update_dr = 0; err_clr = 0;
  endtask

  logic so_s [0:8];
  int   seq [0:7] = '{0, 1, 1, 0, 1, 0, 0, 1};
  int   off;

  initial begin
    rst = 1; capture_dr = 0; shift_dr = 0; update_dr = 0; si = 0; err_clr = 0;
    mode = 1; data_in = 8'h00;
    @(posedge clk);
    #2;
    check_en = 1;
    // Test 1: reset state
    chk("rst_data_out", {24'h0, data_out}, 32'hA5);
    chk("rst_so", {31'h0, so}, 32'h0);
    chk("rst_err", {31'h0, shift_len_err}, 32'h0);
    rst = 0;
    mode = 0; data_in = 8'h3C;
    #1;
    chk("transparent", {24'h0, data_out}, 32'h3C);

    // Test 2: full-length shift
    data_in = 8'h96;
    cyc(1, 0, 0, 0, 0);
    so_s[0] = so;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 1, 0);
      so_s[i+1] = so;
    end
`ifdef DW_BSR_SO_RETIME_EN
    off = 1;
`else
    off = 0;
`endif
    for (int k = 0; k < 8; k++) chk("so_seq", {31'h0, so_s[k+off]}, seq[k]);
    mode = 1;
    cyc(0, 0, 1, 0, 0);
    chk("full_upd", {24'h0, data_out}, 32'hFF);
    chk("full_err", {31'h0, shift_len_err}, 32'h0);

    // Test 3: short shift flags error, clear, zero-shift update stays clean
    data_in = 8'hC3;
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("short_err", {31'h0, shift_len_err}, 32'h1);
    chk("short_upd", {24'h0, data_out}, 32'h06);
    cyc(0, 0, 0, 0, 1);
    chk("clr_err", {31'h0, shift_len_err}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("noshift_err", {31'h0, shift_len_err}, 32'h0);

    // Test 4: capture and update together
    data_in = 8'h5A;
    cyc(1, 0, 0, 0, 0);
    data_in = 8'h0F;
    cyc(1, 0, 1, 0, 0);
    chk("capupd_upd", {24'h0, data_out}, 32'h5A);
    cyc(0, 0, 1, 0, 0);
    chk("capupd_cap", {24'h0, data_out}, 32'h0F);
    chk("capupd_err", {31'h0, shift_len_err}, 32'h0);

    // Test 5: reset mid-shift, then clean full pass
    data_in = 8'h33;
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 1, 0);
    rst = 1;
    cyc(0, 0, 0, 0, 0);
    rst = 0;
    chk("midrst_upd", {24'h0, data_out}, 32'hA5);
    chk("midrst_so", {31'h0, so}, 32'h0);
    data_in = 8'h12;
    cyc(1, 0, 0, 0, 0);
    repeat (8) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("after_rst_err", {31'h0, shift_len_err}, 32'h0);
    chk("after_rst_upd", {24'h0, data_out}, 32'h00);

    // Overlong shift saturates the counter and still flags
    data_in = 8'hE7;
    cyc(1, 0, 0, 0, 0);
    repeat (17) cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    chk("long_err", {31'h0, shift_len_err}, 32'h1);
    cyc(0, 0, 0, 0, 1);
    // Set beats clear in the same cycle; shifts in IDLE are not counted
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    chk("set_over_clr", {31'h0, shift_len_err}, 32'h1);
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    chk("idle_shift_err", {31'h0, shift_len_err}, 32'h0);
    mode = 0; data_in = 8'h81;
    repeat (2) cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
